// File: rtl/lotr_trc_pkg.sv
// Shared types and default sizing for the gpc data-memory access tracer.
package lotr_trc_pkg;

    localparam int TRC_NUM_THREADS = 4;
    localparam int TRC_TID_W       = $clog2(TRC_NUM_THREADS);
    localparam int TRC_ADDR_W      = 32;
    localparam int TRC_DATA_W      = 32;
    localparam int TRC_DEPTH       = 16;
    localparam int TRC_OVF_W       = 16;
    localparam int TRC_REC_W       = 1 + TRC_TID_W + TRC_ADDR_W + TRC_DATA_W;
    localparam int TRC_CNT_W       = $clog2(TRC_DEPTH + 1);

    // One trace record, most significant field first.
    typedef struct packed {
        logic                  is_wr;
        logic [TRC_TID_W-1:0]  tid;
        logic [TRC_ADDR_W-1:0] addr;
        logic [TRC_DATA_W-1:0] data;
    } t_trc_rec;

endpackage

// File: rtl/gpc_trc_fifo.sv
// Circular trace buffer with show-ahead head, separate occupancy count,
// and a choice between overwriting the oldest record or dropping the newest
// when a push arrives while full.
module gpc_trc_fifo #(
    parameter int DEPTH = 16,
    parameter int REC_W = 67,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             wrap,
    input  logic [REC_W-1:0] din,
    output logic [REC_W-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             ovf_inc
);

    logic [REC_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic empty_s;
    logic full_s;
    logic do_pop_s;
    logic do_wr_s;
    logic adv_rd_s;
    logic cnt_inc_s;
    logic cnt_dec_s;
    logic ovf_s;

    // Decide what the buffer does this cycle from push/pop/full/wrap.
    always_comb begin
        empty_s   = (count_r == {CNT_W{1'b0}});
        full_s    = (count_r == CNT_W'(DEPTH));
        do_pop_s  = pop & ~empty_s;
        do_wr_s   = 1'b0;
        adv_rd_s  = do_pop_s;
        ovf_s     = 1'b0;
        if (push) begin
            if (!full_s || do_pop_s) begin
                do_wr_s = 1'b1;
            end else if (wrap) begin
                // Overwrite oldest: the write slot is the head slot, so both advance.
                do_wr_s  = 1'b1;
                adv_rd_s = 1'b1;
                ovf_s    = 1'b1;
            end else begin
                ovf_s = 1'b1;
            end
        end else begin
            do_wr_s = 1'b0;
        end
        cnt_inc_s = push & ~full_s & ~do_pop_s;
        cnt_dec_s = do_pop_s & ~push;
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (adv_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (cnt_inc_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (cnt_dec_s) begin
                count_r <= count_r - CNT_W'(1);
            end
        end
    end

    // Record storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign head    = mem_r[rd_ptr_r];
    assign count   = count_r;
    assign full    = full_s;
    assign ovf_inc = ovf_s;

endmodule

// File: rtl/gpc_mem_trace_buf.sv
// Data-memory access tracer: stages the Q103H request into Q104H, pairs it
// with the load data, filters by thread and stores records in a circular
// buffer drained through a show-ahead pop port.
module gpc_mem_trace_buf
    import lotr_trc_pkg::*;
#(
    parameter int NUM_THREADS = TRC_NUM_THREADS,
    parameter int DEPTH       = TRC_DEPTH,
    parameter int ADDR_W      = TRC_ADDR_W,
    parameter int DATA_W      = TRC_DATA_W,
    parameter int OVF_W       = TRC_OVF_W,
    localparam int TID_W      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int REC_W      = 1 + TID_W + ADDR_W + DATA_W,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                   QClk,
    input  logic                   RstQnnnH,
    input  logic                   CtrlMemRdQ103H,
    input  logic                   CtrlMemWrQ103H,
    input  logic [TID_W-1:0]       ThreadIdQ103H,
    input  logic [ADDR_W-1:0]      MemAdrsQ103H,
    input  logic [DATA_W-1:0]      MemWrDataWQ103H,
    input  logic [DATA_W-1:0]      MemRdDataQ104H,
    input  logic                   CfgEnable,
    input  logic                   CfgWrapMode,
    input  logic [NUM_THREADS-1:0] CfgThreadMask,
    input  logic                   TrcPopQ,
    output logic                   TrcValidQ,
    output logic [REC_W-1:0]       TrcRecQ,
    output logic [CNT_W-1:0]       TrcCountQ,
    output logic [OVF_W-1:0]       TrcOvfCntQ,
    output logic                   TrcBadAccessQ
);

    logic              rd_q104_r;
    logic              wr_q104_r;
    logic [TID_W-1:0]  tid_q104_r;
    logic [ADDR_W-1:0] adrs_q104_r;
    logic [DATA_W-1:0] wrdata_q104_r;

    logic              capture_s;
    logic              bad_s;
    logic [DATA_W-1:0] rec_data_s;
    logic [REC_W-1:0]  rec_s;

    logic [REC_W-1:0]  head_s;
    logic [CNT_W-1:0]  count_s;
    logic              fifo_full_s;
    logic              fifo_ovf_s;
    logic              ovf_step_s;

    logic [OVF_W-1:0]  ovf_cnt_r;
    logic              bad_r;

    // Q104H stage: the request is re-timed unconditionally every cycle.
    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            rd_q104_r     <= 1'b0;
            wr_q104_r     <= 1'b0;
            tid_q104_r    <= {TID_W{1'b0}};
            adrs_q104_r   <= {ADDR_W{1'b0}};
            wrdata_q104_r <= {DATA_W{1'b0}};
        end else begin
            rd_q104_r     <= CtrlMemRdQ103H;
            wr_q104_r     <= CtrlMemWrQ103H;
            tid_q104_r    <= ThreadIdQ103H;
            adrs_q104_r   <= MemAdrsQ103H;
            wrdata_q104_r <= MemWrDataWQ103H;
        end
    end

    // Filter and record formation; config is sampled live at Q104H.
    always_comb begin
        capture_s  = 1'b0;
        rec_data_s = wrdata_q104_r;
        if (rd_q104_r ^ wr_q104_r) begin
            capture_s = CfgEnable & CfgThreadMask[tid_q104_r];
        end else begin
            capture_s = 1'b0;
        end
        if (rd_q104_r) begin
            rec_data_s = MemRdDataQ104H;
        end else begin
            rec_data_s = wrdata_q104_r;
        end
        bad_s = rd_q104_r & wr_q104_r;
        rec_s = {wr_q104_r, tid_q104_r, adrs_q104_r, rec_data_s};
    end

    gpc_trc_fifo #(
        .DEPTH (DEPTH),
        .REC_W (REC_W)
    ) u_fifo (
        .clk     (QClk),
        .rst     (RstQnnnH),
        .push    (capture_s),
        .pop     (TrcPopQ),
        .wrap    (CfgWrapMode),
        .din     (rec_s),
        .head    (head_s),
        .count   (count_s),
        .full    (fifo_full_s),
        .ovf_inc (fifo_ovf_s)
    );

    // A lost record can only happen while full; qualifying keeps the counter
    // from moving on anything but a genuine overflow.
    assign ovf_step_s = fifo_ovf_s & fifo_full_s;

    // Saturating count of dropped or overwritten records.
    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            ovf_cnt_r <= {OVF_W{1'b0}};
        end else if (ovf_step_s && (ovf_cnt_r != {OVF_W{1'b1}})) begin
            ovf_cnt_r <= ovf_cnt_r + OVF_W'(1);
        end
    end

    // Sticky flag for a request that claims to be both load and store.
    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            bad_r <= 1'b0;
        end else if (bad_s) begin
            bad_r <= 1'b1;
        end
    end

    // Head is shown only while valid so an empty buffer presents all zeros.
    assign TrcValidQ     = (count_s != {CNT_W{1'b0}});
    assign TrcRecQ       = TrcValidQ ? head_s : {REC_W{1'b0}};
    assign TrcCountQ     = count_s;
    assign TrcOvfCntQ    = ovf_cnt_r;
    assign TrcBadAccessQ = bad_r;

endmodule

// File: tb/tb_gpc_mem_trace_buf.sv
// Scoreboard bench for gpc_mem_trace_buf: a queue model of the buffer is
// updated as accesses reach Q104H and compared on every pop and state check.
module tb_gpc_mem_trace_buf;
    import lotr_trc_pkg::*;

    localparam int NT = 4;
    localparam int DEPTH = 16;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int OW = 16;
    localparam int TW = 2;
    localparam int RW = 1 + TW + AW + DW;
    localparam int CW = 5;

    logic QClk = 1'b0;
    always #5 QClk = ~QClk;

    logic          RstQnnnH;
    logic          CtrlMemRdQ103H, CtrlMemWrQ103H;
    logic [TW-1:0] ThreadIdQ103H;
    logic [AW-1:0] MemAdrsQ103H;
    logic [DW-1:0] MemWrDataWQ103H, MemRdDataQ104H;
    logic          CfgEnable, CfgWrapMode;
    logic [NT-1:0] CfgThreadMask;
    logic          TrcPopQ;
    logic          TrcValidQ;
    logic [RW-1:0] TrcRecQ;
    logic [CW-1:0] TrcCountQ;
    logic [OW-1:0] TrcOvfCntQ;
    logic          TrcBadAccessQ;

    gpc_mem_trace_buf #(
        .NUM_THREADS (NT), .DEPTH (DEPTH), .ADDR_W (AW), .DATA_W (DW), .OVF_W (OW)
    ) dut (
        .QClk (QClk), .RstQnnnH (RstQnnnH),
        .CtrlMemRdQ103H (CtrlMemRdQ103H), .CtrlMemWrQ103H (CtrlMemWrQ103H),
        .ThreadIdQ103H (ThreadIdQ103H), .MemAdrsQ103H (MemAdrsQ103H),
        .MemWrDataWQ103H (MemWrDataWQ103H), .MemRdDataQ104H (MemRdDataQ104H),
        .CfgEnable (CfgEnable), .CfgWrapMode (CfgWrapMode), .CfgThreadMask (CfgThreadMask),
        .TrcPopQ (TrcPopQ), .TrcValidQ (TrcValidQ), .TrcRecQ (TrcRecQ),
        .TrcCountQ (TrcCountQ), .TrcOvfCntQ (TrcOvfCntQ), .TrcBadAccessQ (TrcBadAccessQ)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [RW-1:0] exp_q [$];
    int            m_ovf = 0;
    bit            m_bad = 1'b0;
    bit            p_rd = 1'b0, p_wr = 1'b0;
    logic [TW-1:0] p_tid = '0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wd = '0, p_rdv = '0, nxt_rdv = '0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag);
        check_val({tag, ".count"}, TrcCountQ, exp_q.size());
        check_val({tag, ".valid"}, TrcValidQ, exp_q.size() != 0);
        check_val({tag, ".ovf"}, TrcOvfCntQ, m_ovf);
        check_val({tag, ".bad"}, TrcBadAccessQ, m_bad);
        if (exp_q.size() != 0) check_val({tag, ".head"}, TrcRecQ, exp_q[0]);
        else check_val({tag, ".head0"}, TrcRecQ, '0);
    endtask

    // One clock: model the Q104H access and pop of the current cycle, then advance.
    task automatic step();
        logic [RW-1:0] rec;
        bit cap, do_pop, full_b;
        MemRdDataQ104H = p_rd ? p_rdv : DW'($urandom());
        full_b = (exp_q.size() == DEPTH);
        do_pop = TrcPopQ && (exp_q.size() > 0);
        if (do_pop) check_val("pop_rec", TrcRecQ, exp_q.pop_front());
        if (p_rd && p_wr) m_bad = 1'b1;
        cap = (p_rd ^ p_wr) && CfgEnable && CfgThreadMask[p_tid];
        rec = {p_wr, p_tid, p_addr, (p_rd ? p_rdv : p_wd)};
        if (cap) begin
            if (!full_b || do_pop) exp_q.push_back(rec);
            else begin
                if (CfgWrapMode) begin
                    void'(exp_q.pop_front());
                    exp_q.push_back(rec);
                end
                if (m_ovf < 65535) m_ovf++;
            end
        end
        @(posedge QClk);
        p_rd = CtrlMemRdQ103H; p_wr = CtrlMemWrQ103H; p_tid = ThreadIdQ103H;
        p_addr = MemAdrsQ103H; p_wd = MemWrDataWQ103H; p_rdv = nxt_rdv;
        #1;
    endtask

    task automatic acc(input bit rd, input bit wr, input int tid, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdv);
        CtrlMemRdQ103H = rd; CtrlMemWrQ103H = wr; ThreadIdQ103H = TW'(tid);
        MemAdrsQ103H = a; MemWrDataWQ103H = wd; nxt_rdv = rdv;
        step();
        CtrlMemRdQ103H = 1'b0; CtrlMemWrQ103H = 1'b0; ThreadIdQ103H = '0;
        MemAdrsQ103H = '0; MemWrDataWQ103H = '0; nxt_rdv = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pop1();
        TrcPopQ = 1'b1;
        step();
        TrcPopQ = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2 RstQnnnH = 1'b1;
        #1;
        check_val("rst.valid", TrcValidQ, 1'b0);
        check_val("rst.rec", TrcRecQ, '0);
        check_val("rst.count", TrcCountQ, '0);
        check_val("rst.ovf", TrcOvfCntQ, '0);
        check_val("rst.bad", TrcBadAccessQ, 1'b0);
        exp_q.delete(); m_ovf = 0; m_bad = 1'b0;
        p_rd = 1'b0; p_wr = 1'b0; p_tid = '0; p_addr = '0; p_wd = '0; p_rdv = '0;
        @(posedge QClk);
        #3 RstQnnnH = 1'b0;
        @(posedge QClk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        t_trc_rec r_ld;
        RstQnnnH = 1'b1; CtrlMemRdQ103H = 1'b0; CtrlMemWrQ103H = 1'b0;
        ThreadIdQ103H = '0; MemAdrsQ103H = '0; MemWrDataWQ103H = '0; MemRdDataQ104H = '0;
        CfgEnable = 1'b1; CfgWrapMode = 1'b1; CfgThreadMask = 4'hF; TrcPopQ = 1'b0;
        repeat (2) @(posedge QClk);
        #3 RstQnnnH = 1'b0;
        @(posedge QClk);
        #1;
        check_state("init");

        // T1: reset with content in the buffer
        for (int i = 0; i < 3; i++) acc(1'b0, 1'b1, i, 32'h100 + i, 32'hA0 + i, 32'h0);
        idle(1);
        check_val("t1.count_pre", TrcCountQ, 5'd3);
        do_reset();
        check_state("t1.post");

        // T2: load pairs with next-cycle read data
        acc(1'b1, 1'b0, 2, 32'h400, 32'h0, 32'hDEADBEEF);
        idle(1);
        r_ld = '{is_wr: 1'b0, tid: 2'd2, addr: 32'h400, data: 32'hDEADBEEF};
        check_val("t2.valid", TrcValidQ, 1'b1);
        check_val("t2.rec", TrcRecQ, r_ld);
        pop1();
        check_state("t2.post");

        // T3: thread filter
        CfgThreadMask = 4'b0001;
        for (int t = 0; t < 4; t++) acc(1'b0, 1'b1, t, 32'h200 + t, 32'h50 + t, 32'h0);
        idle(1);
        check_val("t3.count", TrcCountQ, 5'd1);
        check_val("t3.tid", TrcRecQ[RW-2 -: TW], 2'd0);
        check_state("t3");
        pop1();
        CfgThreadMask = 4'hF;

        // T4: overflow with wrap, then with drop
        CfgWrapMode = 1'b1;
        for (int i = 0; i < 20; i++) acc(1'b0, 1'b1, i % 4, 32'h1000 + i, i, 32'h0);
        idle(1);
        check_val("t4w.count", TrcCountQ, 5'd16);
        check_val("t4w.head", TrcRecQ[DW-1:0], 32'd4);
        check_val("t4w.ovf", TrcOvfCntQ, 16'd4);
        check_state("t4w");
        do_reset();
        CfgWrapMode = 1'b0;
        for (int i = 0; i < 20; i++) acc(1'b0, 1'b1, i % 4, 32'h1000 + i, i, 32'h0);
        idle(1);
        check_val("t4d.count", TrcCountQ, 5'd16);
        check_val("t4d.head", TrcRecQ[DW-1:0], 32'd0);
        check_val("t4d.ovf", TrcOvfCntQ, 16'd4);

        // T5: push and pop together while full
        acc(1'b0, 1'b1, 1, 32'h2000, 32'd100, 32'h0);
        pop1();
        check_val("t5.count", TrcCountQ, 5'd16);
        check_val("t5.ovf", TrcOvfCntQ, 16'd4);
        check_val("t5.head", TrcRecQ[DW-1:0], 32'd1);
        check_state("t5");
        for (int i = 0; i < 16; i++) pop1();
        check_state("t5.drain");

        // T6: rd and wr together, and pop while empty
        do_reset();
        acc(1'b1, 1'b1, 0, 32'h300, 32'h11, 32'h22);
        idle(1);
        check_val("t6.bad", TrcBadAccessQ, 1'b1);
        check_val("t6.count", TrcCountQ, 5'd0);
        idle(100);
        check_val("t6.bad_hold", TrcBadAccessQ, 1'b1);
        pop1();
        check_val("t6.pop_empty_cnt", TrcCountQ, 5'd0);
        check_val("t6.pop_empty_vld", TrcValidQ, 1'b0);
        check_state("t6");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            int op;
            if (i % 50 == 0) begin
                CfgThreadMask = NT'($urandom());
                CfgWrapMode = 1'($urandom());
                CfgEnable = ($urandom_range(0, 7) != 0);
            end
            op = $urandom_range(0, 2);
            CtrlMemRdQ103H = (op == 1);
            CtrlMemWrQ103H = (op == 2);
            ThreadIdQ103H = TW'($urandom());
            MemAdrsQ103H = $urandom();
            MemWrDataWQ103H = $urandom();
            nxt_rdv = $urandom();
            TrcPopQ = ($urandom_range(0, 2) == 0);
            step();
            check_state("rnd");
        end
        CtrlMemRdQ103H = 1'b0; CtrlMemWrQ103H = 1'b0; TrcPopQ = 1'b0;
        idle(2);
        check_state("end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
